// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM demultiplexer.
// Optional frame counter: TDM_DEMUX_FRAME_CNT_EN.
package tdm_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int FRAME_CNT_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Stream-in / channels-out bundle of the TDM demultiplexer.
// frame_cnt exists only with TDM_DEMUX_FRAME_CNT_EN.
interface tdm_demux_if
  import tdm_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 1
);
  logic [DATA_W-1:0]        din;
  logic                     din_valid;
  logic                     frame_sync;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic                     frame_done;
  logic                     locked;
  logic                     sync_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0]   frame_cnt;
`endif

  modport master (
    output din,
    output din_valid,
    output frame_sync,
`ifdef TDM_DEMUX_FRAME_CNT_EN
    input  frame_cnt,
`endif
    input  ch_data,
    input  ch_valid,
    input  frame_done,
    input  locked,
    input  sync_err
  );

  modport slave (
    input  din,
    input  din_valid,
    input  frame_sync,
`ifdef TDM_DEMUX_FRAME_CNT_EN
    output frame_cnt,
`endif
    output ch_data,
    output ch_valid,
    output frame_done,
    output locked,
    output sync_err
  );
endinterface

// File: rtl/tdm_ch_counter.sv
// Modulo-NUM_CH channel counter with clear, load-to-1 and increment.
// Wraps at NUM_CH-1 so non-power-of-two sizes never reach a bad index.
module tdm_ch_counter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load1,
  input  logic            inc,
  output logic [CH_W-1:0] cnt,
  output logic            last
);
  logic [CH_W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == CH_W'(NUM_CH - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)        cnt_d = '0;
    else if (load1) cnt_d = CH_W'(1);
    else if (inc)   cnt_d = last ? '0 : cnt_q + CH_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tdm_demux.sv
// Round-robin TDM demultiplexer aligned by a channel-0 frame sync.
// Optional 16-bit frame counter: TDM_DEMUX_FRAME_CNT_EN.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 1
) (
  input logic        clk,
  input logic        rst_n,
  tdm_demux_if.slave bus
);
  localparam int CH_W = clog2(NUM_CH);

  state_e                   state_q, state_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic [NUM_CH-1:0]        valid_q, valid_d;
  logic                     fd_q, fd_d;
  logic                     se_q, se_d;
  logic                     inc, load1, last;
  logic [CH_W-1:0]          cnt;
  logic                     take_sync, take_data;

  tdm_ch_counter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .load1 (load1),
    .inc   (inc),
    .cnt   (cnt),
    .last  (last)
  );

  assign take_sync = bus.din_valid
                   & bus.frame_sync;
  assign take_data = bus.din_valid
                   & ~bus.frame_sync
                   & (state_q == ST_LOCKED);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = '0;
    fd_d    = 1'b0;
    se_d    = 1'b0;
    inc     = 1'b0;
    load1   = 1'b0;
    unique case (1'b1)
      take_sync: begin
        load1              = 1'b1;
        data_d[DATA_W-1:0] = bus.din;
        valid_d[0]         = 1'b1;
        // a sync inside a frame truncates it
        se_d    = (state_q == ST_LOCKED)
                & (cnt != '0);
        state_d = ST_LOCKED;
      end
      take_data: begin
        inc = 1'b1;
        data_d[int'(cnt)*DATA_W +: DATA_W] = bus.din;
        valid_d[cnt] = 1'b1;
        fd_d         = last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      data_q  <= '0;
      valid_q <= '0;
      fd_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
      se_q    <= se_d;
    end
  end

`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (fd_d) fcnt_d = fcnt_q + FRAME_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcnt_q <= '0;
    else        fcnt_q <= fcnt_d;
  end

  assign bus.frame_cnt = fcnt_q;
`endif

  assign bus.ch_data    = data_q;
  assign bus.ch_valid   = valid_q;
  assign bus.frame_done = fd_q;
  assign bus.sync_err   = se_q;
  assign bus.locked     = (state_q == ST_LOCKED);
endmodule
